// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types for the branch redirect unit
// Purpose: branch redirect FSM state encoding and the legal delay-slot counts.
// Ports:   none (package).
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    HOLD    = 2'd2
  } br_state_t;

  // Only "no delay slot" and "one delay slot" are meaningful for this pipeline.
  localparam int DS_SLOTS_NONE = 0;
  localparam int DS_SLOTS_ONE  = 1;

endpackage

// File: rtl/br_stat_cnt.sv
// rtl/br_stat_cnt.sv - taken / not-taken branch statistics counters
// Purpose: two free-running counters that wrap at 2^CNT_W.
// Ports:   clk, rst_n (async active-low)
//          inc_taken, inc_ntaken    one-cycle increment strobes (mutually exclusive)
//          stat_taken, stat_ntaken  current counts
module br_stat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_taken,
  input  logic             inc_ntaken,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_ntaken
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken  <= '0;
      stat_ntaken <= '0;
    end else begin
      if (inc_taken)  stat_taken  <= stat_taken + 1'b1;
      if (inc_ntaken) stat_ntaken <= stat_ntaken + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - ID-stage branch outcome to IF-stage PC redirect
// Purpose: turns a resolved taken branch into one PC redirect offered to IF,
//          waiting DS_SLOTS delay-slot fetches first, holding it across IF
//          stalls and stalling ID (br_busy) while it is outstanding.
//          Optional statistics counters are built when BR_STAT_EN is defined;
//          otherwise stat_taken/stat_ntaken read 0.
// Ports:   clk, rst_n (async active-low)
//          br_valid, br_taken, br_target   resolved branch from ID
//          if_fetch                        IF fetched an instruction (delay slot)
//          if_ready                        IF accepts the redirect this cycle
//          flush                           cancel any pending redirect
//          redirect_valid, redirect_pc     redirect offered to IF
//          br_busy                         stall ID
//          stat_taken, stat_ntaken         branch statistics
module branch_redirect
  import mips_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DS_SLOTS = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [AW-1:0]    br_target,
  input  logic             if_fetch,
  input  logic             if_ready,
  input  logic             flush,
  output logic             redirect_valid,
  output logic [AW-1:0]    redirect_pc,
  output logic             br_busy,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_ntaken
);

  br_state_t     state, state_nxt;
  logic [AW-1:0] target_q;
  logic          accept;

  // A branch is only taken in while idle; a flush in the same cycle discards it.
  assign accept = br_valid && (state == IDLE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (br_valid && br_taken)
                 state_nxt = (DS_SLOTS == DS_SLOTS_ONE) ? WAIT_DS : HOLD;
      WAIT_DS: if (if_fetch) state_nxt = HOLD;
      HOLD:    if (if_ready) state_nxt = IDLE;   // if_fetch is irrelevant here
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // The target is kept after the redirect completes; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  target_q <= '0;
    else if (accept && br_taken) target_q <= br_target;
  end

  assign redirect_valid = (state == HOLD);
  assign redirect_pc    = target_q;
  assign br_busy        = (state != IDLE);

`ifdef BR_STAT_EN
  br_stat_cnt #(
    .CNT_W (CNT_W)
  ) u_stat (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_taken   (accept && br_taken),
    .inc_ntaken  (accept && !br_taken),
    .stat_taken  (stat_taken),
    .stat_ntaken (stat_ntaken)
  );
`else
  assign stat_taken  = '0;
  assign stat_ntaken = '0;
`endif

endmodule
